// File: rtl/demux38_reg.sv
// Registered 1:3 demux: words steered by Sinal into three single-entry buffers, visible the cycle after acceptance.
// Pronto drops only when the addressed buffer is full and not draining; invalid codes are always accepted and counted.
module demux38_reg #(
  parameter int LARGURA    = 8,
  parameter int LARG_ERROS = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [LARGURA-1:0]    Dado,
  input  logic [1:0]            Sinal,
  input  logic                  Valido,
  output logic                  Pronto,
  output logic [LARGURA-1:0]    Saida0,
  output logic [LARGURA-1:0]    Saida1,
  output logic [LARGURA-1:0]    Saida2,
  output logic                  Valido0,
  output logic                  Valido1,
  output logic                  Valido2,
  input  logic                  Pronto0,
  input  logic                  Pronto1,
  input  logic                  Pronto2,
  output logic [LARG_ERROS-1:0] Erros
);

  logic [LARGURA-1:0]    saida_q [3];
  logic [LARGURA-1:0]    saida_d [3];
  logic [2:0]            valido_q, valido_d;
  logic [LARG_ERROS-1:0] erros_q, erros_d;

  logic [2:0] cons_rdy;
  logic [2:0] sai;
  logic [2:0] carga;
  logic       aceita;
  logic       pronto_rdy;

  assign cons_rdy = {Pronto2, Pronto1, Pronto0};

  always_comb begin
    pronto_rdy = 1'b1;
    case (Sinal)
      2'b00:   pronto_rdy = ~valido_q[0] | cons_rdy[0];
      2'b01:   pronto_rdy = ~valido_q[1] | cons_rdy[1];
      2'b10:   pronto_rdy = ~valido_q[2] | cons_rdy[2];
      default: pronto_rdy = 1'b1;
    endcase
  end

  assign aceita = Valido & pronto_rdy;

  always_comb begin
    erros_d = erros_q;
    for (int k = 0; k < 3; k++) begin
      sai[k]     = valido_q[k] & cons_rdy[k];
      carga[k]   = aceita & (Sinal == 2'(k));
      // A load in the same cycle as a drain keeps the buffer full (no bubble).
      saida_d[k]  = carga[k] ? Dado : saida_q[k];
      valido_d[k] = carga[k] | (valido_q[k] & ~sai[k]);
    end
    if (aceita && (Sinal == 2'b11) && (erros_q != {LARG_ERROS{1'b1}}))
      erros_d = erros_q + 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int k = 0; k < 3; k++) saida_q[k] <= '0;
      valido_q <= '0;
      erros_q  <= '0;
    end else begin
      for (int k = 0; k < 3; k++) saida_q[k] <= saida_d[k];
      valido_q <= valido_d;
      erros_q  <= erros_d;
    end
  end

  assign Pronto  = pronto_rdy;
  assign Saida0  = saida_q[0];
  assign Saida1  = saida_q[1];
  assign Saida2  = saida_q[2];
  assign Valido0 = valido_q[0];
  assign Valido1 = valido_q[1];
  assign Valido2 = valido_q[2];
  assign Erros   = erros_q;

endmodule

// File: tb/tb_demux38_reg.sv
// Bench for demux38_reg: directed scenarios plus randomized traffic against a queue-based reference.
module tb_demux38_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dado;
  logic [1:0] sinal;
  logic       valido;
  logic       pronto;
  logic [7:0] saida0, saida1, saida2;
  logic       valido0, valido1, valido2;
  logic       p0, p1, p2;
  logic [7:0] erros;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux38_reg #(.LARGURA(8), .LARG_ERROS(8)) dut (
    .Clock(clk), .Reset(rst), .Dado(dado), .Sinal(sinal), .Valido(valido),
    .Pronto(pronto),
    .Saida0(saida0), .Saida1(saida1), .Saida2(saida2),
    .Valido0(valido0), .Valido1(valido1), .Valido2(valido2),
    .Pronto0(p0), .Pronto1(p1), .Pronto2(p2),
    .Erros(erros)
  );

  logic [7:0] out_dat [3];
  logic       out_vld [3];
  assign out_dat[0] = saida0;
  assign out_dat[1] = saida1;
  assign out_dat[2] = saida2;
  assign out_vld[0] = valido0;
  assign out_vld[1] = valido1;
  assign out_vld[2] = valido2;

  // Reference: each channel is a queue of pending words plus the last word loaded.
  logic [7:0] mq [3][$];
  logic [7:0] last_dat [3];
  int         err_cnt;
  bit         last_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit cons_ready(input int k);
    return (k == 0) ? p0 : (k == 1) ? p1 : p2;
  endfunction

  function automatic bit model_pronto();
    if (sinal == 2'b11) return 1'b1;
    return (mq[sinal].size() == 0) || cons_ready(int'(sinal));
  endfunction

  function automatic int model_erros();
    return (err_cnt > 255) ? 255 : err_cnt;
  endfunction

  task automatic set_in(input bit v, input logic [1:0] s, input logic [7:0] d);
    valido = v;
    sinal  = s;
    dado   = d;
  endtask

  // Check current outputs at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    bit mp;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("valido%0d", k), 32'(out_vld[k]), 32'(mq[k].size() != 0));
      chk($sformatf("saida%0d", k), 32'(out_dat[k]), 32'(last_dat[k]));
    end
    chk("erros", 32'(erros), 32'(model_erros()));
    mp = model_pronto();
    chk("pronto", 32'(pronto), 32'(mp));
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        mq[k].delete();
        last_dat[k] = 8'h00;
      end
      err_cnt  = 0;
      last_acc = 1'b1;
    end else begin
      for (int k = 0; k < 3; k++)
        if (mq[k].size() != 0 && cons_ready(k)) void'(mq[k].pop_front());
      last_acc = valido && mp;
      if (last_acc) begin
        if (sinal == 2'b11) err_cnt++;
        else begin
          mq[sinal].push_back(dado);
          last_dat[sinal] = dado;
        end
      end
    end
    #1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) last_dat[k] = 8'h00;
    err_cnt  = 0;
    last_acc = 1'b1;
    rst = 1'b1; p0 = 1'b0; p1 = 1'b0; p2 = 1'b0;
    set_in(1'b0, 2'b00, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset/idle state
    cycle();
    chk("idle_pronto", 32'(pronto), 32'd1);
    chk("idle_valido0", 32'(valido0), 32'd0);

    // Channel 1 stall and pass-through
    set_in(1'b1, 2'b01, 8'hA5); cycle();
    chk("ch1_first", 32'(saida1), 32'hA5);
    set_in(1'b1, 2'b01, 8'h3C);
    repeat (4) cycle();
    chk("ch1_stall_pronto", 32'(pronto), 32'd0);
    chk("ch1_stall_saida", 32'(saida1), 32'hA5);
    p1 = 1'b1;
    #1 chk("ch1_release_pronto", 32'(pronto), 32'd1);
    cycle();
    chk("ch1_second", 32'(saida1), 32'h3C);
    chk("ch1_no_bubble", 32'(valido1), 32'd1);
    set_in(1'b0, 2'b01, 8'h00); cycle();

    // Channel 2 streaming
    p2 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      set_in(1'b1, 2'b10, 8'(i)); cycle();
      chk("ch2_stream", 32'(saida2), 32'(i));
    end
    set_in(1'b0, 2'b10, 8'h00); cycle();

    // Stalled channel 0 does not block channel 2
    p0 = 1'b0;
    set_in(1'b1, 2'b00, 8'h11); cycle();
    set_in(1'b1, 2'b10, 8'h77); cycle();
    chk("ch2_bypass", 32'(saida2), 32'h77);
    chk("ch0_held", 32'(saida0), 32'h11);
    set_in(1'b0, 2'b00, 8'h00); cycle();

    // Invalid code counting and saturation
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 2'b11, 8'(i)); cycle();
    end
    chk("erros_three", 32'(erros), 32'd3);
    for (int i = 0; i < 260; i++) begin
      set_in(1'b1, 2'b11, 8'(i)); cycle();
    end
    chk("erros_sat", 32'(erros), 32'hFF);
    chk("erros_sat_pronto", 32'(pronto), 32'd1);

    // Reset with full stalled channels and a word presented
    p0 = 1'b0; p1 = 1'b0; p2 = 1'b0;
    set_in(1'b1, 2'b00, 8'h5A); cycle();
    set_in(1'b1, 2'b01, 8'hC3); cycle();
    rst = 1'b1;
    set_in(1'b1, 2'b10, 8'hEE); cycle();
    rst = 1'b0;
    set_in(1'b0, 2'b00, 8'h00);
    chk("rst_valido0", 32'(valido0), 32'd0);
    chk("rst_valido1", 32'(valido1), 32'd0);
    chk("rst_valido2", 32'(valido2), 32'd0);
    chk("rst_saida0", 32'(saida0), 32'd0);
    chk("rst_saida2", 32'(saida2), 32'd0);
    chk("rst_erros", 32'(erros), 32'd0);
    cycle();

    // Randomized traffic; source holds its word until accepted
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      p0 = ($urandom_range(0, 2) != 0);
      p1 = ($urandom_range(0, 1) != 0);
      p2 = ($urandom_range(0, 3) == 0);
      if (!valido || last_acc)
        set_in(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux38_reg.md
# demux38_reg

Registered 1-to-3 demultiplexer with valid/ready handshaking: the distribution end of the datapath's 3:1 selection muxes. A single 8-bit source stream carries a 2-bit destination code per word; each word is steered into one of three single-entry output buffers, each drained independently by its own consumer. Words with the unused destination code are dropped and counted, so the source never stalls on a bad code.

## Interface
Parameters:
- `LARGURA`, default 8: data word width.
- `LARG_ERROS`, default 8: width of the dropped-word counter.

Ports:
- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: reset is synchronous and active-high.
- `Dado` in `LARGURA`: input word.
- `Sinal` in 2: destination of `Dado`. Encodings: 2'b00 → channel 0, 2'b01 → channel 1, 2'b10 → channel 2, 2'b11 → invalid.
- `Valido` in 1: `Dado`/`Sinal` valid.
- `Pronto` out 1: block accepts the current word.
- `Saida0`, `Saida1`, `Saida2` out `LARGURA`: channel output words.
- `Valido0`, `Valido1`, `Valido2` out 1: channel buffer holds a word.
- `Pronto0`, `Pronto1`, `Pronto2` in 1: channel consumer ready.
- `Erros` out `LARG_ERROS`: count of dropped words, saturating.

## Operation
- Per channel k: one data register `Saida_k` and a full flag, driven out as `Valido_k`.
- Input transfer: `aceita = Valido & Pronto`.
- Output transfer on channel k: `sai_k = Valido_k & Pronto_k`.
- `Pronto` is combinational from `Sinal`, the full flags and `Pronto0..2`. It never depends on `Valido`.
  - `Sinal` = 2'b11: `Pronto` = 1. An invalid code is always accepted.
  - Otherwise: `Pronto = ~Valido_k | Pronto_k` for k = `Sinal`. A full buffer draining this cycle still accepts a new word (pass-through, full throughput).
- On `aceita` with `Sinal` = k (k = 0..2):
  - `Saida_k <= Dado`.
  - `Valido_k <= 1`.
  - If `sai_k` also occurs in the same cycle, the load wins and `Valido_k` stays 1.
- On `sai_k` without a load to k: `Valido_k <= 0`. `Saida_k` holds its last value; it is not cleared.
- On `aceita` with `Sinal` = 2'b11:
  - Word is discarded; no channel changes.
  - `Erros <= Erros + 1`, saturating at all-ones (255 for the default width).
- Channels are independent. A stalled channel blocks only words addressed to it; a word for another channel is accepted in the same cycle.
- While `Valido_k` = 1 and `Pronto_k` = 0, `Saida_k` and `Valido_k` are stable.
- No reordering within a channel. Ordering across channels is not defined.

## Timing
- Reset (synchronous, takes effect on the clock edge while `Reset` = 1):
  - `Valido0..2` = 0, `Saida0..2` = 0, `Erros` = 0.
  - Buffered words are discarded without delivery.
  - `Reset` overrides any simultaneous accept or drain.
  - During reset `Pronto` is still evaluated combinationally, but no transfer is recorded.
- Latency: a word accepted at edge N appears on `Saida_k` with `Valido_k` = 1 immediately after edge N, so it is visible in cycle N+1.
- Throughput: one word per cycle per channel when its consumer holds `Pronto_k` = 1; aggregate one word per cycle (single input).
- Full-buffer boundary: `Valido_k` = 1 and `Pronto_k` = 0 with `Sinal` = k gives `Pronto` = 0. The source must hold `Dado`/`Sinal`/`Valido` until `Pronto` = 1.
- Simultaneous load and drain on the same channel: the old word leaves, the new word is registered, `Valido_k` stays 1 (no bubble).
- `Erros` at all-ones plus another invalid word: stays at all-ones; `Pronto` remains 1.
- `Sinal` changes while `Valido` = 0: no effect on state.

## Test plan
- Reset then idle: all `Valido_k` = 0, `Saida_k` = 8'h00, `Erros` = 0. With `Sinal` = 2'b00 and `Valido0` = 0, `Pronto` = 1.
- Send 8'hA5 to channel 1 with `Pronto1` = 0 → next cycle `Saida1` = 8'hA5, `Valido1` = 1. Then send 8'h3C to channel 1 → `Pronto` = 0, held 4 cycles with `Saida1` stable at 8'hA5. Raise `Pronto1` → `Pronto` = 1 the same cycle; next cycle `Saida1` = 8'h3C with `Valido1` still 1.
- Stream 8'h01..8'h08 to channel 2 with `Pronto2` = 1 throughout → `Pronto` = 1 every cycle and `Saida2` sequence 01..08 on consecutive cycles, no gaps.
- Channel 0 full and stalled; send 8'h77 to channel 2 → accepted the same cycle and delivered on `Saida2`; channel 0 word unchanged.
- Send 3 words with `Sinal` = 2'b11 → `Pronto` = 1, no `Valido_k` change, `Erros` = 3. Force 260 invalid words → `Erros` = 8'hFF.
- Load channels 0 and 1 (both stalled), assert `Reset` for one cycle together with a valid word → `Valido0..2` = 0, `Saida0..2` = 0, `Erros` = 0, and the word presented during reset is not delivered.
